// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: single CPU word accesses and fixed-length VGA read bursts
// share one memory port with fixed read latency; fair alternation on conflicts.
module mem_arbiter #(
  parameter int MEM_LAT   = 1,
  parameter int VGA_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byte_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        vga_req,
  input  logic [31:0] vga_addr,
  output logic [31:0] vga_rdata,
  output logic        vga_valid,
  output logic        vga_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  // Handshake: cpu_req / vga_req are held until cpu_ack / vga_done; a request seen in the
  // same cycle as its own completion pulse is treated as already serviced.
  typedef enum logic [2:0] {IDLE, CPU_ISSUE, CPU_WAIT, VGA_ISSUE, VGA_DRAIN} state_t;

  localparam int              BW        = $clog2(VGA_BURST);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(VGA_BURST - 1);
  localparam logic [1:0]      LAT       = 2'(MEM_LAT);

  state_t              state_q, state_d;
  logic                last_vga_q, last_vga_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [1:0]          wait_q, wait_d;
  logic [MEM_LAT-1:0]  pipe_q, pipe_d, pipe_last_q, pipe_last_d;
  logic [MEM_LAT:0]    pipe_ext, pipe_last_ext;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_byte_en_q, mem_byte_en_d;
  logic [31:0]         cpu_rdata_q, cpu_rdata_d, vga_rdata_q, vga_rdata_d;
  logic                cpu_ack_q, cpu_ack_d, vga_valid_q, vga_valid_d, vga_done_q, vga_done_d;
  logic                cpu_v, vga_v, vga_issue, vga_last;

  always_comb begin
    cpu_v     = cpu_req & ~cpu_ack_q;
    vga_v     = vga_req & ~vga_done_q;
    vga_issue = (state_q == VGA_ISSUE);
    vga_last  = vga_issue && (beat_q == LAST_BEAT);

    // Bit j of the pipes marks a VGA read issued j+1 cycles ago; the top bit means mem_rdata is live.
    pipe_ext      = {pipe_q, vga_issue};
    pipe_last_ext = {pipe_last_q, vga_last};
    pipe_d        = pipe_ext[MEM_LAT-1:0];
    pipe_last_d   = pipe_last_ext[MEM_LAT-1:0];

    state_d       = state_q;
    last_vga_d    = last_vga_q;
    beat_d        = beat_q;
    wait_d        = wait_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = 32'h0;
    mem_wdata_d   = 32'h0;
    mem_byte_en_d = 4'h0;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    vga_valid_d   = pipe_q[MEM_LAT-1];
    vga_done_d    = pipe_last_q[MEM_LAT-1];
    vga_rdata_d   = pipe_q[MEM_LAT-1] ? mem_rdata : vga_rdata_q;

    case (state_q)
      IDLE: begin
        if (vga_v && (!cpu_v || !last_vga_q)) begin
          state_d       = VGA_ISSUE;
          last_vga_d    = 1'b1;
          beat_d        = '0;
          mem_en_d      = 1'b1;
          mem_addr_d    = vga_addr & 32'hFFFF_FFFC;
          mem_byte_en_d = 4'hF;
        end else if (cpu_v) begin
          state_d       = CPU_ISSUE;
          last_vga_d    = 1'b0;
          mem_en_d      = 1'b1;
          mem_we_d      = cpu_we;
          mem_addr_d    = cpu_addr;
          mem_wdata_d   = cpu_wdata;
          mem_byte_en_d = cpu_we ? cpu_byte_en : 4'hF;
        end
      end
      CPU_ISSUE: begin
        if (mem_we_q) begin
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d  = 2'd1;
          state_d = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        if (wait_q == LAT) begin
          cpu_rdata_d = mem_rdata;
          cpu_ack_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      VGA_ISSUE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = VGA_DRAIN;
        end else begin
          beat_d        = beat_q + BW'(1);
          mem_en_d      = 1'b1;
          mem_addr_d    = mem_addr_q + 32'd4;
          mem_byte_en_d = 4'hF;
        end
      end
      VGA_DRAIN: begin
        if (pipe_last_q[MEM_LAT-1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_vga_q    <= 1'b0;
      beat_q        <= '0;
      wait_q        <= 2'd0;
      pipe_q        <= '0;
      pipe_last_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_byte_en_q <= 4'h0;
      cpu_rdata_q   <= 32'h0;
      cpu_ack_q     <= 1'b0;
      vga_rdata_q   <= 32'h0;
      vga_valid_q   <= 1'b0;
      vga_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_vga_q    <= last_vga_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      pipe_q        <= pipe_d;
      pipe_last_q   <= pipe_last_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      vga_rdata_q   <= vga_rdata_d;
      vga_valid_q   <= vga_valid_d;
      vga_done_q    <= vga_done_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_stall   = cpu_req & ~cpu_ack_q;
  assign vga_rdata   = vga_rdata_q;
  assign vga_valid   = vga_valid_q;
  assign vga_done    = vga_done_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_en = mem_byte_en_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MEM_LAT=1, VGA_BURST=8) with a read-data memory model and
// expected-value queues for CPU read data, VGA burst addresses and VGA burst data.
module tb_mem_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0, S_CPU_ISSUE = 3'd1, S_VGA_ISSUE = 3'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        vga_req;
  logic [31:0] vga_addr, vga_rdata;
  logic        vga_valid, vga_done;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata = 32'h0;
  logic [2:0]  dbg_state;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] cpu_exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .VGA_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata), .vga_valid(vga_valid),
    .vga_done(vga_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h200) ? 32'h1234_5678 : ((a ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  // One-cycle read latency memory
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? model(mem_addr) : 32'h0;

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'h0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'h0);
    chk({tag, "_vga_rdata"}, vga_rdata, 32'h0);
    chk({tag, "_vga_valid"}, 32'(vga_valid), 32'h0);
    chk({tag, "_vga_done"}, 32'(vga_done), 32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_be"}, 32'(mem_byte_en), 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Runs one VGA burst from the cycle it is requested through the vga_done cycle.
  task automatic vga_burst(input logic [31:0] base, input bit stall_chk, input bit keep_req);
    int first_issue = -1, last_issue = -1, first_valid = -1, n_issue = 0;
    bit done = 1'b0;
    logic [31:0] a;
    a = base & 32'hFFFF_FFFC;
    for (int i = 0; i < 8; i++) begin
      addr_q.push_back(a + 32'(4 * i));
      exp_q.push_back(model(a + 32'(4 * i)));
    end
    vga_addr = base;
    vga_req  = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      if (stall_chk) begin
        chk("burst_cpu_stall", 32'(cpu_stall), 32'h1);
        chk("burst_cpu_ack", 32'(cpu_ack), 32'h0);
      end
      if (mem_en) begin
        chk("vga_mem_we", 32'(mem_we), 32'h0);
        chk("vga_mem_be", 32'(mem_byte_en), 32'hF);
        chk("vga_mem_addr", mem_addr, (addr_q.size() > 0) ? addr_q.pop_front() : 32'hxxxx_xxxx);
        if (first_issue < 0) first_issue = cyc_n;
        last_issue = cyc_n;
        n_issue++;
      end
      if (vga_valid) begin
        if (first_valid < 0) first_valid = cyc_n;
        chk("vga_rdata", vga_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
      end
      if (vga_done) begin
        chk("vga_done_with_last", 32'(exp_q.size()), 32'h0);
        chk("vga_done_valid", 32'(vga_valid), 32'h1);
        chk("vga_done_state", 32'(dbg_state), 32'(S_IDLE));
        done = 1'b1;
        if (!keep_req) vga_req = 1'b0;
      end
    end
    chk("vga_done_seen", 32'(done), 32'h1);
    chk("vga_issue_count", 32'(n_issue), 32'd8);
    chk("vga_issue_span", 32'(last_issue - first_issue), 32'd7);
    chk("vga_first_latency", 32'(first_valid - first_issue), 32'd2);
    chk("vga_addr_q_empty", 32'(addr_q.size()), 32'h0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_byte_en = 4'h0; vga_req = 1'b0; vga_addr = 32'h0;
    repeat (3) cyc();
    chk_all_zero("reset");
    reset = 1'b0;
    cyc();

    // CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEAD_BEEF; cpu_byte_en = 4'b0011;
    cyc();
    chk("wr_t1_mem_en", 32'(mem_en), 32'h1);
    chk("wr_t1_mem_we", 32'(mem_we), 32'h1);
    chk("wr_t1_mem_addr", mem_addr, 32'h100);
    chk("wr_t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("wr_t1_mem_be", 32'(mem_byte_en), 32'b0011);
    chk("wr_t1_ack", 32'(cpu_ack), 32'h0);
    chk("wr_t1_stall", 32'(cpu_stall), 32'h1);
    cyc();
    chk("wr_t2_ack", 32'(cpu_ack), 32'h1);
    chk("wr_t2_stall", 32'(cpu_stall), 32'h0);
    chk("wr_t2_mem_en", 32'(mem_en), 32'h0);
    chk("wr_t2_state", 32'(dbg_state), 32'(S_IDLE));
    cpu_req = 1'b0;
    cyc();
    chk("wr_t3_ack", 32'(cpu_ack), 32'h0);
    chk("wr_t3_mem_we", 32'(mem_we), 32'h0);

    // CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200; cpu_byte_en = 4'b0001;
    cpu_exp_q.push_back(32'h1234_5678);
    cyc();
    chk("rd_t1_mem_en", 32'(mem_en), 32'h1);
    chk("rd_t1_mem_we", 32'(mem_we), 32'h0);
    chk("rd_t1_mem_addr", mem_addr, 32'h200);
    chk("rd_t1_mem_be", 32'(mem_byte_en), 32'hF);
    cyc();
    chk("rd_t2_ack", 32'(cpu_ack), 32'h0);
    chk("rd_t2_mem_en", 32'(mem_en), 32'h0);
    cyc();
    chk("rd_t3_ack", 32'(cpu_ack), 32'h1);
    chk("rd_t3_rdata", cpu_rdata, cpu_exp_q.pop_front());
    chk("rd_t3_state", 32'(dbg_state), 32'(S_IDLE));
    cpu_req = 1'b0;
    cyc();
    cyc();
    chk("rd_hold_rdata", cpu_rdata, 32'h1234_5678);
    chk("rd_hold_ack", 32'(cpu_ack), 32'h0);

    // VGA bursts, unaligned base and address wrap
    vga_burst(32'h8000_0002, 1'b0, 1'b0);
    cyc();
    chk("post_burst_valid", 32'(vga_valid), 32'h0);
    chk("post_burst_done", 32'(vga_done), 32'h0);
    vga_burst(32'hFFFF_FFF0, 1'b0, 1'b0);
    cyc();
    chk("rdata_held_across_vga", cpu_rdata, 32'h1234_5678);

    // Simultaneous requests after reset: VGA first, CPU stalled, then CPU, then VGA again
    reset = 1'b1;
    cyc();
    chk_all_zero("reset2");
    reset = 1'b0;
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'h1122_3344; cpu_byte_en = 4'b1100;
    vga_burst(32'h0000_1000, 1'b1, 1'b1);
    vga_addr = 32'h0000_2000;
    cyc();
    chk("arb_cpu_state", 32'(dbg_state), 32'(S_CPU_ISSUE));
    chk("arb_cpu_mem_we", 32'(mem_we), 32'h1);
    chk("arb_cpu_mem_addr", mem_addr, 32'h300);
    chk("arb_cpu_mem_be", 32'(mem_byte_en), 32'b1100);
    cyc();
    chk("arb_cpu_ack", 32'(cpu_ack), 32'h1);
    cyc();
    chk("arb_vga_next_state", 32'(dbg_state), 32'(S_VGA_ISSUE));
    chk("arb_vga_next_addr", mem_addr, 32'h2000);
    chk("arb_vga_next_stall", 32'(cpu_stall), 32'h1);
    cyc();
    cyc();
    chk("abort_3rd_issue_addr", mem_addr, 32'h2008);
    reset = 1'b1; cpu_req = 1'b0;
    cyc();
    chk_all_zero("abort");
    reset = 1'b0; vga_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (vga_valid || vga_done || cpu_ack || mem_en) seen = 1'b1;
    end
    chk("abort_no_late_activity", 32'(seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
